uart_tx_engine: RTL and testbench

//  - 8N1 UART transmitter; counterpart to the existing UART receive path.
//  - Accepts one byte per valid/ready handshake, serialises it LSB-first on O_rs232_txd at BAUD.
//  - Sits between the CPU UART register block and the board TXD pin; internal baud timing, no external bps clock.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_tick.sv | 38 +++
 rtl/uart_tx_engine.sv | 159 +++++++++++++++
 tb/tb_uart_tx_engine.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, data width and baud-period helper
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Clocks per bit period, truncated toward zero.
  function automatic int bit_cycles(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter with clear/preload, one-cycle tick at BIT_CYCLES-1
module uart_baud_tick #(
  parameter int BIT_CYCLES = 868,
  parameter int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] load_i,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  // Count up, wrap after the tick; clear loads the preload value (0 for bit start, mid-bit for a receiver).
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i) begin
      cnt_d = load_i;
    end else if (tick_o) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - 8N1 UART transmitter; optional parity bit with UART_TX_PARITY_EN
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int PARITY_ODD = 0
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_tx_valid,
  input  logic [7:0] I_tx_data,
  output logic       O_tx_ready,
  output logic       O_tx_done,
  output logic       O_tx_busy,
  output logic       O_rs232_txd
);

  localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD);
  localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  // The stop state runs one period short; the registered done/IDLE cycle supplies
  // the final stop-bit clock, so a byte accepted there starts with no idle gap.
  localparam logic [CNT_W-1:0] STOP_LOAD = CNT_W'(1);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           idx_q, idx_d;
  logic                 txd_q, txd_d;
  logic                 done_q, done_d;
  logic                 baud_clr;
  logic [CNT_W-1:0]     baud_load;
  logic                 baud_tick;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  uart_baud_tick #(
    .BIT_CYCLES(BIT_CYCLES),
    .CNT_W     (CNT_W)
  ) u_baud (
    .I_clk  (I_clk),
    .I_rst_n(I_rst_n),
    .clr_i  (baud_clr),
    .load_i (baud_load),
    .tick_o (baud_tick)
  );

  assign O_tx_ready  = (state_q == ST_IDLE);
  assign O_tx_busy   = ~O_tx_ready;
  assign O_tx_done   = done_q;
  assign O_rs232_txd = txd_q;

  // Frame sequencing: next state, next line level and bit-period control.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    txd_d     = txd_q;
    done_d    = 1'b0;
    baud_clr  = 1'b0;
    baud_load = '0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        baud_clr = 1'b1;
        txd_d    = 1'b1;
        if (I_tx_valid) begin
          state_d  = ST_START;
          shift_d  = I_tx_data;
          idx_d    = '0;
          txd_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = (^I_tx_data) ^ 1'(PARITY_ODD);
`endif
        end
      end
      ST_START: begin
        if (baud_tick) begin
          state_d  = ST_DATA;
          txd_d    = shift_q[0];
          idx_d    = '0;
          baud_clr = 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          baud_clr = 1'b1;
          if (idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d   = ST_PARITY;
            txd_d     = parity_q;
`else
            state_d   = ST_STOP;
            txd_d     = 1'b1;
            baud_load = STOP_LOAD;
`endif
          end else begin
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
            idx_d   = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_tick) begin
          state_d   = ST_STOP;
          txd_d     = 1'b1;
          baud_clr  = 1'b1;
          baud_load = STOP_LOAD;
        end
      end
`endif
      ST_STOP: begin
        if (baud_tick) begin
          state_d = ST_IDLE;
          txd_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  // State, shift register, bit index and registered line/done outputs.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity of the accepted byte, fixed for the whole frame.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - self-checking bench: per-cycle line model, UART decoder, directed and random bytes
`timescale 1ns/1ps
module tb_uart_tx_engine;

  localparam int CLK_FREQ   = 100_000_000;
  localparam int BAUD       = 115200;
  localparam int BC         = CLK_FREQ / BAUD;
  localparam int PARITY_ODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Line cycles in one frame; done is reported in the frame's last cycle.
  localparam int FRAME = NBITS * BC;

  logic       I_clk      = 1'b0;
  logic       I_rst_n    = 1'b0;
  logic       I_tx_valid = 1'b0;
  logic [7:0] I_tx_data  = 8'h00;
  logic       O_tx_ready, O_tx_done, O_tx_busy, O_rs232_txd;

  uart_tx_engine #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .I_clk      (I_clk),
    .I_rst_n    (I_rst_n),
    .I_tx_valid (I_tx_valid),
    .I_tx_data  (I_tx_data),
    .O_tx_ready (O_tx_ready),
    .O_tx_done  (O_tx_done),
    .O_tx_busy  (O_tx_busy),
    .O_rs232_txd(O_rs232_txd)
  );

  always #5 I_clk = ~I_clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: one in-flight frame described by its first-low cycle and byte.
  bit         m_active = 1'b0;
  int         m_start  = 0;
  logic [7:0] m_byte   = 8'h00;
  logic       e_txd, e_rdy, e_done;

  int         acc_q[$];
  int         fall_q[$];
  int         done_q[$];
  logic [7:0] rx_q[$];
  int         low_count = 0;
  logic       prev_txd  = 1'b1;
  logic       tb_rdy    = 1'b1;
  bit         rx_on     = 1'b0;
  int         rx_t0     = 0;
  int         rx_off, rx_k;
  logic [7:0] rx_sh     = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line level in cycle t: start 0, data LSB first, optional parity, then stop/idle 1.
  function automatic logic model_txd(input int t);
    int k;
    if (!m_active || t < m_start) return 1'b1;
    k = (t - m_start) / BC;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    if (NBITS == 11 && k == 9) return (^m_byte) ^ 1'(PARITY_ODD);
    return 1'b1;
  endfunction

  // Per-cycle compare against the model, event logging, decoder, then model advance.
  always @(negedge I_clk) begin
    if (!I_rst_n) begin
      m_active = 1'b0;
      e_txd    = 1'b1;
      e_rdy    = 1'b1;
      e_done   = 1'b0;
    end else begin
      e_txd  = model_txd(cyc);
      e_done = m_active && (cyc == m_start + FRAME - 1);
      e_rdy  = !m_active || e_done;
    end
    chk("txd",   O_rs232_txd, e_txd);
    chk("ready", O_tx_ready,  e_rdy);
    chk("busy",  O_tx_busy,   !e_rdy);
    chk("done",  O_tx_done,   e_done);

    if (O_tx_done) done_q.push_back(cyc);
    if (!O_rs232_txd) low_count++;
    if (I_rst_n && prev_txd && !O_rs232_txd) fall_q.push_back(cyc);

    if (!I_rst_n) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (prev_txd && !O_rs232_txd) begin
        rx_on = 1'b1;
        rx_t0 = cyc;
      end
    end else begin
      rx_off = cyc - rx_t0;
      if (rx_off >= BC + BC / 2 && (rx_off - BC / 2) % BC == 0) begin
        rx_k = (rx_off - BC / 2) / BC;
        if (rx_k <= 8) begin
          rx_sh[rx_k-1] = O_rs232_txd;
        end else if (rx_k == NBITS - 1) begin
          chk("stop_bit", O_rs232_txd, 1'b1);
          rx_q.push_back(rx_sh);
          rx_on = 1'b0;
        end
      end
    end
    prev_txd = O_rs232_txd;
    tb_rdy   = O_tx_ready;

    if (I_rst_n) begin
      if (I_tx_valid && e_rdy) begin
        m_active = 1'b1;
        m_start  = cyc + 1;
        m_byte   = I_tx_data;
        acc_q.push_back(cyc);
      end else if (e_done) begin
        m_active = 1'b0;
      end
    end
    cyc++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge I_clk);
    #1;
  endtask

  // Present a byte and hold valid until the edge that accepts it (bounded).
  task automatic send(input logic [7:0] b);
    bit ok;
    ok         = 1'b0;
    I_tx_valid = 1'b1;
    I_tx_data  = b;
    for (int n = 0; n < 30000; n++) begin
      @(posedge I_clk);
      if (tb_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    chk("send_accept", ok, 1'b1);
  endtask

  initial begin
    int nd, nf, na;
    logic [7:0] r1, r2;
    logic [7:0] exp_rx[$];

    // Reset state
    repeat (3) @(negedge I_clk);
    chk("rst_txd",   O_rs232_txd, 1'b1);
    chk("rst_ready", O_tx_ready,  1'b1);
    chk("rst_busy",  O_tx_busy,   1'b0);
    chk("rst_done",  O_tx_done,   1'b0);
    @(posedge I_clk);
    #1 I_rst_n = 1'b1;
    step(1000);
    chk("idle_low_cycles", low_count, 0);

    // 0x55: latency, done position, decoded value
    na = acc_q.size(); nf = fall_q.size(); nd = done_q.size();
    send(8'h55);
    I_tx_valid = 1'b0;
    step(FRAME + 20);
    chk("t55_latency",     fall_q[nf] - acc_q[na], 1);
    chk("t55_done_offset", done_q[nd] - fall_q[nf], (NBITS == 11) ? 9547 : 8679);
    chk("t55_done_count",  done_q.size() - nd, 1);
    exp_rx.push_back(8'h55);

    // Busy rejection
    nd = done_q.size();
    send(8'hA3);
    I_tx_valid = 1'b0;
    step(3000);
    I_tx_valid = 1'b1;
    I_tx_data  = 8'hFF;
    step(1);
    I_tx_valid = 1'b0;
    step(FRAME);
    chk("busy_done_count", done_q.size() - nd, 1);
    exp_rx.push_back(8'hA3);

    // Back-to-back with valid held
    nd = done_q.size(); nf = fall_q.size();
    send(8'h00);
    send(8'hFF);
    I_tx_valid = 1'b0;
    step(2 * FRAME + 20);
    chk("b2b_done_count", done_q.size() - nd, 2);
    chk("b2b_done_gap",   done_q[nd+1] - done_q[nd], FRAME);
    chk("b2b_no_gap",     fall_q[nf+1] - done_q[nd], 1);
    exp_rx.push_back(8'h00);
    exp_rx.push_back(8'hFF);

    // Reset during bit 3 of 0x0F
    nd = done_q.size();
    send(8'h0F);
    I_tx_valid = 1'b0;
    step(4 * BC + 400);
    I_rst_n = 1'b0;
    #1;
    chk("midrst_txd",   O_rs232_txd, 1'b1);
    chk("midrst_ready", O_tx_ready,  1'b1);
    step(5);
    I_rst_n = 1'b1;
    step(FRAME);
    chk("midrst_no_done", done_q.size() - nd, 0);

    send(8'h81);
    I_tx_valid = 1'b0;
    step(FRAME + 20);
    exp_rx.push_back(8'h81);

    // Random bytes after a random idle gap, back-to-back
    r1 = 8'($urandom);
    r2 = 8'($urandom);
    step($urandom_range(1, 50));
    send(r1);
    send(r2);
    I_tx_valid = 1'b0;
    step(2 * FRAME + 20);
    exp_rx.push_back(r1);
    exp_rx.push_back(r2);

    chk("rx_count", rx_q.size(), exp_rx.size());
    foreach (exp_rx[i]) begin
      chk($sformatf("rx_byte%0d", i), rx_q[i], exp_rx[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
